// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int LOCK_CNT_W = 4;
  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_ZERO = 4'd0;
  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_ONE  = 4'd1;

  // Saturating increment of the burst-lock counter.
  function automatic logic [LOCK_CNT_W-1:0] lock_cnt_inc(
    input logic [LOCK_CNT_W-1:0] cnt,
    input logic [LOCK_CNT_W-1:0] max_cnt
  );
    logic [LOCK_CNT_W-1:0] res;
    if (cnt >= max_cnt) begin
      res = cnt;
    end else begin
      res = cnt + LOCK_CNT_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker with an optional forced winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_en,
  input  logic       lock_port,
  output logic [1:0] gnt
);

  // One-hot pick: the forced port if it requests, otherwise the port that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (lock_en && req[lock_port]) begin
      gnt = lock_port ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin with a bounded
// burst lock, same-cycle grant and a one-cycle read-return tag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic              p0_lock,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] MemData
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(MAX_LOCK);

  arb_state_e            state_r, state_nxt_s;
  logic                  owner_r, owner_nxt_s;
  logic                  last_r, last_nxt_s;
  logic [LOCK_CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
  logic [1:0]            rd_tag_r, rd_tag_nxt_s;

  logic [1:0] req_s;
  logic [1:0] lock_s;
  logic       other_s;
  logic       owner_hold_s;
  logic       forced_s;
  logic [1:0] pick_gnt_s;
  logic [1:0] gnt_s;
  logic       any_gnt_s;
  logic       win_s;
  logic       win_we_s;

  assign req_s   = {p1_req, p0_req};
  assign lock_s  = {p1_lock, p0_lock};
  assign other_s = ~owner_r;

  // A locking owner keeps the memory until the counter hits the cap with the other port waiting.
  assign owner_hold_s = (state_r == LOCKED) && req_s[owner_r] && lock_s[owner_r];
  assign forced_s     = owner_hold_s && (lock_cnt_r == LOCK_MAX) && req_s[other_s];

  rr_pick2 u_pick (
    .req       (req_s),
    .last      (last_r),
    .lock_en   (owner_hold_s),
    .lock_port (forced_s ? other_s : owner_r),
    .gnt       (pick_gnt_s)
  );

  // Grant gating: nothing is granted while reset is held.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      gnt_s = pick_gnt_s;
    end
  end

  assign any_gnt_s = |gnt_s;
  assign win_s     = gnt_s[1];
  assign win_we_s  = win_s ? p1_we : p0_we;

  // Memory command mux and read-return tag for the winning port.
  always_comb begin
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Address      = {ADDR_W{1'b0}};
    Write_data   = {DATA_W{1'b0}};
    rd_tag_nxt_s = 2'b00;
    if (any_gnt_s) begin
      MemRead      = ~win_we_s;
      MemWrite     = win_we_s;
      Address      = win_s ? p1_addr : p0_addr;
      Write_data   = win_s ? p1_wdata : p0_wdata;
      rd_tag_nxt_s = win_we_s ? 2'b00 : gnt_s;
    end else begin
      rd_tag_nxt_s = 2'b00;
    end
  end

  // Next-state: owner hold / forced release, else the plain round-robin outcome.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    last_nxt_s     = last_r;
    lock_cnt_nxt_s = lock_cnt_r;
    if (forced_s) begin
      state_nxt_s    = UNLOCKED;
      last_nxt_s     = other_s;
      lock_cnt_nxt_s = LOCK_CNT_ZERO;
    end else if (owner_hold_s) begin
      last_nxt_s = owner_r;
      if (req_s[other_s]) begin
        lock_cnt_nxt_s = lock_cnt_inc(lock_cnt_r, LOCK_MAX);
      end else begin
        lock_cnt_nxt_s = lock_cnt_r;
      end
    end else if (any_gnt_s) begin
      last_nxt_s = win_s;
      if (lock_s[win_s]) begin
        state_nxt_s    = LOCKED;
        owner_nxt_s    = win_s;
        lock_cnt_nxt_s = LOCK_CNT_ONE;
      end else begin
        state_nxt_s    = UNLOCKED;
        lock_cnt_nxt_s = LOCK_CNT_ZERO;
      end
    end else begin
      state_nxt_s    = UNLOCKED;
      lock_cnt_nxt_s = LOCK_CNT_ZERO;
    end
  end

  // State, lock counter and read tag registers; reset drops any outstanding read.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_r    <= UNLOCKED;
      owner_r    <= P0;
      last_r     <= P1;
      lock_cnt_r <= LOCK_CNT_ZERO;
      rd_tag_r   <= 2'b00;
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      last_r     <= last_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      rd_tag_r   <= rd_tag_nxt_s;
    end
  end

  assign p0_gnt    = gnt_s[0];
  assign p1_gnt    = gnt_s[1];
  assign p0_rvalid = rd_tag_r[0];
  assign p1_rvalid = rd_tag_r[1];
  assign p0_rdata  = rd_tag_r[0] ? MemData : {DATA_W{1'b0}};
  assign p1_rdata  = rd_tag_r[1] ? MemData : {DATA_W{1'b0}};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: port 0 (core load/store) and port 1 (loader/debug DMA).
- Round-robin arbitration with an optional bounded lock for bursts.
- Drives the memory's MemRead/MemWrite/Address/Write_data and routes the registered MemData back to the owning port.
- Sits directly between the requesters and the memory. There is no buffering beyond the one-cycle read-return tag.

Parameters:
- ADDR_W, 8, address width; must match memory depth (2^ADDR_W entries).
- DATA_W, 8, data width.
- MAX_LOCK, 4, maximum consecutive grants to a locking port while the other port is requesting; range 1..15.

Ports:
- ph1  input  1  clock; all state updates on posedge ph1.
- reset  input  1  synchronous, active-high reset (sampled on posedge ph1).
- p0_req, p1_req  input  1  access request; held with its command until granted.
- p0_we, p1_we  input  1  1 = write, 0 = read.
- p0_lock, p1_lock  input  1  request to keep ownership for following accesses.
- p0_addr, p1_addr  input  ADDR_W  access address.
- p0_wdata, p1_wdata  input  DATA_W  write data.
- p0_gnt, p1_gnt  output  1  combinational; command accepted this cycle.
- p0_rvalid, p1_rvalid  output  1  registered; read data valid this cycle.
- p0_rdata, p1_rdata  output  DATA_W  read data; 0 unless the matching rvalid is 1.
- MemRead  output  1  to memory.
- MemWrite  output  1  to memory.
- Address  output  ADDR_W  to memory.
- Write_data  output  DATA_W  to memory.
- MemData  input  DATA_W  from memory; registered, valid the cycle after MemRead.

Behaviour:
- **Reset (reset=1 at edge):**
  - state=UNLOCKED, last=1 (p0 wins the first contention), lock_cnt=0.
  - rd_tag_valid=0, so both rvalid are 0 the following cycle.
  - While reset is high: gnt, MemRead and MemWrite are forced 0; Address and Write_data are 0.
  - The memory clears itself on the same edge.
  - A reset arriving mid-burst or with a read outstanding drops that read's response silently.
- **Grant:**
  - Combinational in the same cycle as req. At most one gnt per cycle.
  - The winner's command is driven onto the memory in the same cycle; the memory samples it at the next posedge.
- **Idle (no grant):** MemRead=0, MemWrite=0, Address=0, Write_data=0.
- **State UNLOCKED:**
  - One requester: grant it.
  - Both requesters: grant the port != last.
  - On any grant: last <= winner.
  - Winner with lock=1 and req: go to LOCKED(owner=winner), lock_cnt <= 1.
- **State LOCKED(owner):**
  - Owner with req=1 and lock=1 is granted ahead of the other port, except on forced release.
  - lock_cnt increments only on owner grants while the other port is requesting; it saturates at MAX_LOCK.
  - Forced release: lock_cnt==MAX_LOCK and the other port requesting. The other port is granted this cycle; go to UNLOCKED, last <= other.
  - Owner drops lock or req: go to UNLOCKED this cycle, where normal round-robin applies. A grant to the owner with lock=0 still counts as a normal grant.
- **Read return:**
  - For a read granted in cycle N, rX_rvalid=1 in cycle N+1 with rX_rdata=MemData.
  - The tag (valid, port) is registered at the posedge ending cycle N.
  - The non-owning port sees rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- **Throughput and ordering:**
  - One access per cycle. Back-to-back reads from either port return on consecutive cycles in grant order.
  - A write followed by a read of the same address on the next cycle returns the new data, because the memory applies the write at the earlier edge.
- **Stability rule:**
  - Requesters must hold addr, we and wdata stable while req=1 and gnt=0.
  - Changes made while ungranted are legal but only the values in the grant cycle are used.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {UNLOCKED, LOCKED}
  - port index constants P0=0, P1=1
  - lock_cnt width constant LOCK_CNT_W=4
- Sub-module rr_pick2: purely combinational 2-way round-robin picker (req[1:0], last, lock override) producing a one-hot grant.
- FSM, lock counter and read-return tag stay in mem_arbiter.

Test Plan:
- Reset then single read: after reset, write 0xA5 at 0x10 via p0, then p0 read 0x10 -> p0_gnt same cycle, p0_rvalid=1 next cycle with p0_rdata=0xA5; p1_rvalid=0 and p1_rdata=0.
- Contention: both ports read continuously (p0 addr 0x01 holding 0x11, p1 addr 0x02 holding 0x22) -> grants alternate p0,p1,p0,...; rvalid/rdata alternate 0x11/0x22 one cycle later.
- Lock with forced release (MAX_LOCK=4): p1 holds lock+req, p0 requests throughout -> p1 granted 4 consecutive cycles, then p0 granted on the 5th, then state UNLOCKED.
- Lock voluntary release: p0 lock for 2 writes (0x20=0x01, 0x21=0x02) then drops lock, p1 waiting -> p1 granted the cycle after p0 drops lock; reading 0x20 and 0x21 returns 0x01 and 0x02.
- Write-then-read same address: p1 writes 0x7F=0x3C, p0 reads 0x7F the next cycle -> p0_rdata=0x3C.
- Reset mid-read: p0 read granted in cycle N, reset=1 in cycle N -> no rvalid in N+1; all memory reads after reset return 0x00.
